// File: rtl/frame2fifo9_if.sv
// Byte-stream input and 9-bit FIFO write port of the frame packer.
`timescale 1ns/1ps
interface frame2fifo9_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [8:0] din;
    logic       wr_en;
    logic       full;

    modport master (output s_data, s_valid, s_last, full,
                    input  s_ready, din, wr_en);
    modport slave  (input  s_data, s_valid, s_last, full,
                    output s_ready, din, wr_en);
endinterface

// File: rtl/frame2fifo9.sv
// Store-and-forward packer: buffers a frame, pads it to MIN_LEN, bursts it plus gap words into the FIFO.
// First FIFO write 2 cycles after s_last; input is held off (s_ready=0) until the gap is out; full stalls the burst.
`timescale 1ns/1ps
module frame2fifo9 #(
    parameter int MAX_LEN   = 1514,
    parameter int MIN_LEN   = 60,
    parameter int GAP_WORDS = 16,
    parameter int BUF_AW    = 11
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    frame2fifo9_if.slave  bus,
    output logic          wr_clk,
    output logic [15:0]   frame_cnt,
    output logic [15:0]   drop_cnt
);
    localparam int LW = BUF_AW + 1;
    localparam int GW = (GAP_WORDS > 1) ? $clog2(GAP_WORDS) : 1;
    localparam logic [LW-1:0] LAST_IDX = LW'(MAX_LEN - 1);
    localparam logic [LW-1:0] MIN_L    = LW'(MIN_LEN);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_WORDS - 1);

    typedef enum logic [1:0] {RECV, DISCARD, DRAIN, GAP} state_t;

    state_t            state, nxt;
    logic [7:0]        mem [2**BUF_AW];
    logic [LW-1:0]     wptr, len, emit_len, idx, len_next;
    logic [GW-1:0]     gap_cnt;
    logic              primed;
    logic [7:0]        rd_q;
    logic [BUF_AW-1:0] rd_addr;
    logic              accept, fire, last_data, last_gap;

    assign wr_clk    = sys_clk;
    assign accept    = bus.s_valid && bus.s_ready;
    assign fire      = bus.wr_en;
    assign len_next  = wptr + 1'b1;
    assign last_data = (state == DRAIN) && fire && (idx == emit_len - 1'b1);
    assign last_gap  = (state == GAP) && fire && (gap_cnt == GAP_LAST);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= RECV;
        else         state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            RECV: begin
                if (accept) begin
                    if (bus.s_last)            nxt = DRAIN;
                    else if (wptr == LAST_IDX) nxt = DISCARD;
                end
            end
            DISCARD: if (accept && bus.s_last) nxt = RECV;
            DRAIN:   if (last_data)            nxt = GAP;
            GAP:     if (last_gap)             nxt = RECV;
            default:                           nxt = RECV;
        endcase
    end

    // rd_q must already hold buf[idx] when a DRAIN word goes out; primed covers the first read.
    always_comb begin
        bus.s_ready = 1'b0;
        bus.wr_en   = 1'b0;
        bus.din     = 9'h000;
        case (state)
            RECV, DISCARD: bus.s_ready = 1'b1;
            DRAIN: begin
                bus.wr_en = primed && !bus.full;
                bus.din   = {1'b1, (idx < len) ? rd_q : 8'h00};
            end
            GAP:     bus.wr_en = !bus.full;
            default: bus.s_ready = 1'b0;
        endcase
    end

    // Look one word ahead on a successful write so the pipeline sustains one word per cycle.
    assign rd_addr = (state == DRAIN && fire) ? BUF_AW'(idx + 1'b1) : idx[BUF_AW-1:0];

    always_ff @(posedge sys_clk) begin
        if (state == RECV && accept) mem[wptr[BUF_AW-1:0]] <= bus.s_data;
        rd_q <= mem[rd_addr];
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wptr      <= '0;
            len       <= '0;
            emit_len  <= '0;
            idx       <= '0;
            gap_cnt   <= '0;
            primed    <= 1'b0;
            frame_cnt <= 16'h0000;
            drop_cnt  <= 16'h0000;
        end else begin
            primed <= (state == DRAIN);
            case (state)
                RECV: begin
                    if (accept) begin
                        wptr <= len_next;
                        if (bus.s_last) begin
                            len      <= len_next;
                            emit_len <= (len_next < MIN_L) ? MIN_L : len_next;
                            idx      <= '0;
                        end
                    end
                end
                DISCARD: begin
                    if (accept && bus.s_last) begin
                        drop_cnt <= drop_cnt + 16'd1;
                        wptr     <= '0;
                    end
                end
                DRAIN: begin
                    if (fire)      idx     <= idx + 1'b1;
                    if (last_data) gap_cnt <= '0;
                end
                GAP: begin
                    if (fire) gap_cnt <= gap_cnt + 1'b1;
                    if (last_gap) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        wptr      <= '0;
                    end
                end
                default: wptr <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_frame2fifo9.sv
// Directed bench for frame2fifo9: scoreboard of expected FIFO words, stall injection and reset abort.
`timescale 1ns/1ps
module tb_frame2fifo9;
    localparam int GAPW = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        wr_clk;
    logic [15:0] frame_cnt, drop_cnt;

    frame2fifo9_if bus();

    frame2fifo9 #(.MAX_LEN(1514), .MIN_LEN(60), .GAP_WORDS(GAPW), .BUF_AW(11)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .bus       (bus),
        .wr_clk    (wr_clk),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    int         cyc = 0;
    int         wcount = 0;
    bit         in_frame = 0;
    int         zero_run = 0;
    int         last_gap_edge = 0;
    int         first_write_edge = 0;
    int         last_accept_edge = 0;
    int         first_accept_edge = 0;
    int         stall_a = -1;
    int         stall_b = -1;
    int         stall_beats = 0;
    int         exp_frames = 0;

    always @(posedge sys_clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor / scoreboard, plus the only driver of bus.full.
    initial begin
        logic [8:0] exp_w;
        int stall_left;
        stall_left = 0;
        bus.full = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (bus.full) check("wr_en_while_full", {31'b0, bus.wr_en}, 32'd0);
            if (in_frame && !bus.full && !sys_rst) check("underrun", {31'b0, bus.wr_en}, 32'd1);
            if (bus.wr_en === 1'b1) begin
                check("s_ready_during_write", {31'b0, bus.s_ready}, 32'd0);
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_write observed=%0h expected=none", bus.din);
                end
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    check("fifo_word", {23'b0, bus.din}, {23'b0, exp_w});
                end
                wcount++;
                if (bus.din[8]) begin
                    if (!in_frame) first_write_edge = cyc + 1;
                    in_frame = 1;
                    zero_run = 0;
                end else begin
                    in_frame = 0;
                    zero_run++;
                    if (zero_run == GAPW) last_gap_edge = cyc + 1;
                end
            end
            @(posedge sys_clk);
            #1;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) bus.full = 1'b0;
            end else if (wcount == stall_a || wcount == stall_b) begin
                if (wcount == stall_a) stall_a = -1;
                else                   stall_b = -1;
                bus.full   = 1'b1;
                stall_left = 5;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        logic ok;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        bus.s_last  = last;
        do begin
            @(negedge sys_clk);
            ok = bus.s_ready;
            if (ok) last_accept_edge = cyc + 1;
            else    stall_beats++;
            @(posedge sys_clk);
            #1;
            n++;
        end while (!ok && n < 5000);
        if (!ok) check("beat_accept_timeout", {31'b0, ok}, 32'd1);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [7:0] base);
        logic [7:0] b;
        if (len <= 1514) begin
            for (int i = 0; i < len; i++) begin
                b = base + i[7:0];
                exp_q.push_back({1'b1, b});
            end
            for (int i = len; i < 60; i++) exp_q.push_back(9'h100);
            for (int i = 0; i < GAPW; i++) exp_q.push_back(9'h000);
        end
        for (int i = 0; i < len; i++) begin
            b = base + i[7:0];
            send_byte(b, i == len - 1);
            if (i == 0) first_accept_edge = last_accept_edge;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 6000) begin
            @(posedge sys_clk);
            n++;
        end
        repeat (3) @(posedge sys_clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int n;
        sys_rst     = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_s_ready", {31'b0, bus.s_ready}, 32'd1);
        check("rst_wr_en", {31'b0, bus.wr_en}, 32'd0);
        check("rst_din", {23'b0, bus.din}, 32'd0);
        check("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        check("rst_drop_cnt", {16'b0, drop_cnt}, 32'd0);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;

        // 64-byte frame, no backpressure
        w0 = wcount;
        send_frame(64, 8'h00);
        wait_idle();
        exp_frames++;
        check("t1_frame_cnt", {16'b0, frame_cnt}, exp_frames);
        check("t1_words", wcount - w0, 32'd80);
        check("t1_latency_le3", {31'b0, (first_write_edge - last_accept_edge) <= 3}, 32'd1);

        // short frame padded, then 1-byte frame
        w0 = wcount;
        send_frame(10, 8'hA0);
        wait_idle();
        exp_frames++;
        check("t2_words", wcount - w0, 32'd76);
        w0 = wcount;
        send_frame(1, 8'h5A);
        wait_idle();
        exp_frames++;
        check("t2_one_byte_words", wcount - w0, 32'd76);
        check("t2_frame_cnt", {16'b0, frame_cnt}, exp_frames);

        // oversize frame dropped, next frame intact
        w0 = wcount;
        stall_beats = 0;
        send_frame(1515, 8'h33);
        repeat (5) @(posedge sys_clk);
        #1;
        check("t3_no_writes", wcount - w0, 32'd0);
        check("t3_s_ready_held", stall_beats, 32'd0);
        check("t3_drop_cnt", {16'b0, drop_cnt}, 32'd1);
        send_frame(60, 8'h40);
        wait_idle();
        exp_frames++;
        check("t3_frame_cnt", {16'b0, frame_cnt}, exp_frames);

        // maximum-length frame
        w0 = wcount;
        send_frame(1514, 8'h11);
        wait_idle();
        exp_frames++;
        check("t4_words", wcount - w0, 32'd1530);
        check("t4_frame_cnt", {16'b0, frame_cnt}, exp_frames);

        // full stalls at data word 20 and at the last gap word
        w0 = wcount;
        stall_a = w0 + 20;
        stall_b = w0 + 79;
        send_frame(64, 8'h00);
        wait_idle();
        exp_frames++;
        check("t5_stalls_fired", stall_a + stall_b, -32'sd2);
        check("t5_words", wcount - w0, 32'd80);
        check("t5_frame_cnt", {16'b0, frame_cnt}, exp_frames);

        // s_valid held through DRAIN/GAP: next byte taken right after the last gap write
        send_frame(10, 8'hB0);
        send_frame(60, 8'hC0);
        check("t6_accept_after_gap", first_accept_edge - last_gap_edge, 32'd1);
        wait_idle();
        exp_frames += 2;
        check("t6_frame_cnt", {16'b0, frame_cnt}, exp_frames);

        // reset in the middle of DRAIN
        w0 = wcount;
        send_frame(64, 8'h80);
        n = 0;
        while (wcount < w0 + 30 && n < 500) begin
            @(posedge sys_clk);
            #2;
            n++;
        end
        check("t7_reached_word30", {31'b0, wcount >= w0 + 30}, 32'd1);
        sys_rst = 1'b1;
        exp_q.delete();
        in_frame = 0;
        #1;
        check("t7_rst_wr_en", {31'b0, bus.wr_en}, 32'd0);
        check("t7_rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        check("t7_rst_drop_cnt", {16'b0, drop_cnt}, 32'd0);
        check("t7_rst_s_ready", {31'b0, bus.s_ready}, 32'd1);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        w0 = wcount;
        send_frame(60, 8'h22);
        wait_idle();
        check("t7_words", wcount - w0, 32'd76);
        check("t7_frame_cnt", {16'b0, frame_cnt}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
